fbreader: RTL and testbench

- PLB master-read engine; the read-side counterpart of the framebuffer writer.
- Pops pixel read requests (line, col) from a request FIFO and issues single-beat 32-bit PLB reads at the framebuffer address.
- Pushes {line, col, color} into a response FIFO.
- Consumers are read-modify-write and blend stages in the raster pipeline.

---
 rtl/fbreader_pkg.sv | 43 ++++
 rtl/fb_addr_gen.sv | 13 +
 rtl/fbreader.sv | 142 ++++++++++++++
 tb/tb_fbreader.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fbreader_pkg.sv
// Shared definitions for the framebuffer reader and writer: FSM encoding, coordinate widths and field positions.
// Vectors are numbered LSB = 0, so PLB bit 0 (the MSB) is bit N-1 here and numeric values are unchanged.
package fbreader_pkg;

    localparam int LINE_LEN     = 9;
    localparam int COL_LEN      = 10;
    localparam int REQ_FIFO_LEN = 32;
    localparam int RSP_FIFO_LEN = 64;
    localparam int C_MST_AWIDTH = 32;
    localparam int C_MST_DWIDTH = 32;

    localparam logic [10:0] FB_BASE_ADDR = 11'b1001_0000_000;

    localparam int REQ_LINE_LSB  = 16;
    localparam int REQ_COL_LSB   = 0;
    localparam int RSP_LINE_LSB  = 48;
    localparam int RSP_COL_LSB   = 32;
    localparam int RSP_COLOR_LSB = 0;

    typedef enum logic [3:0] {
        IDLE       = 4'd0,
        PRESENT    = 4'd1,
        WAIT_ACK   = 4'd2,
        WAIT_CMPLT = 4'd3,
        ERROR      = 4'd4,
        FIFO_READ  = 4'd5,
        PUSH       = 4'd6
    } fb_state_t;

    function automatic logic [RSP_FIFO_LEN-1:0] pack_rsp(
        input logic [LINE_LEN-1:0]     line,
        input logic [COL_LEN-1:0]      col,
        input logic [C_MST_DWIDTH-1:0] color
    );
        logic [RSP_FIFO_LEN-1:0] w;
        w = '0;
        w[RSP_LINE_LSB +: 16]            = 16'(line);
        w[RSP_COL_LSB +: 16]             = 16'(col);
        w[RSP_COLOR_LSB +: C_MST_DWIDTH] = color;
        return w;
    endfunction

endpackage

// File: rtl/fb_addr_gen.sv
// Pixel (line, col) to PLB byte address; one 32-bit word per pixel, 1024-pixel line stride.
// Purely combinational, zero latency, no flow control.
module fb_addr_gen
    import fbreader_pkg::*;
(
    input  logic [LINE_LEN-1:0]     line,
    input  logic [COL_LEN-1:0]      col,
    output logic [C_MST_AWIDTH-1:0] addr
);

    assign addr = {FB_BASE_ADDR, line, col, 2'b00};

endmodule

// File: rtl/fbreader.sv
// PLB single-beat read engine: pops a (line, col) request, reads one pixel, pushes {line, col, color}.
// At least 5 cycles per pixel; waits in PUSH while the response FIFO is full and never drops a completed read.
module fbreader
    import fbreader_pkg::*;
(
    input  logic                      PLB_clk,
    input  logic                      reset,
    output logic [3:0]                state,
    input  logic [REQ_FIFO_LEN-1:0]   req_data,
    input  logic                      req_empty,
    output logic                      req_rd_en,
    output logic [RSP_FIFO_LEN-1:0]   rsp_data,
    input  logic                      rsp_full,
    output logic                      rsp_wr_en,
    output logic                      IP2Bus_MstRd_Req,
    output logic                      IP2Bus_MstWr_Req,
    output logic [C_MST_AWIDTH-1:0]   IP2Bus_Mst_Addr,
    output logic [C_MST_DWIDTH/8-1:0] IP2Bus_Mst_BE,
    output logic                      IP2Bus_Mst_Lock,
    output logic                      IP2Bus_Mst_Reset,
    input  logic                      Bus2IP_Mst_CmdAck,
    input  logic                      Bus2IP_Mst_Cmplt,
    input  logic                      Bus2IP_Mst_Error,
    input  logic                      Bus2IP_Mst_Rearbitrate,
    input  logic                      Bus2IP_Mst_Cmd_Timeout,
    input  logic [C_MST_DWIDTH-1:0]   Bus2IP_MstRd_d,
    input  logic                      Bus2IP_MstRd_src_rdy_n,
    output logic                      IP2Bus_MstRd_dst_rdy_n,
    output logic [C_MST_DWIDTH-1:0]   IP2Bus_MstWr_d
);

    fb_state_t             st_q, st_d;
    logic [LINE_LEN-1:0]   line_q;
    logic [COL_LEN-1:0]    col_q;
    logic [C_MST_DWIDTH-1:0] color_q;
    logic                  err;
    logic                  rd_phase;
    logic                  pop_d;
    logic                  push_d;
    logic [LINE_LEN-1:0]   req_line;
    logic [COL_LEN-1:0]    req_col;
    logic [LINE_LEN-1:0]   addr_line;
    logic [COL_LEN-1:0]    addr_col;
    logic                  unused_in;

    assign err      = Bus2IP_Mst_Error | Bus2IP_Mst_Cmd_Timeout | reset;
    assign rd_phase = (st_q == WAIT_ACK) || (st_q == WAIT_CMPLT);
    assign req_line = req_data[REQ_LINE_LSB +: LINE_LEN];
    assign req_col  = req_data[REQ_COL_LSB +: COL_LEN];

    // Rearbitrate needs no action: the request stays asserted until CmdAck.
    assign unused_in = ^{Bus2IP_Mst_Rearbitrate, req_data[31:25], req_data[15:10]};

    always_comb begin
        st_d   = st_q;
        pop_d  = 1'b0;
        push_d = 1'b0;
        case (st_q)
            IDLE: begin
                if (err) begin
                    st_d = ERROR;
                end else if (!req_empty && !rsp_full) begin
                    st_d  = FIFO_READ;
                    pop_d = 1'b1;
                end
            end
            FIFO_READ:  st_d = err ? ERROR : PRESENT;
            PRESENT:    st_d = err ? ERROR : WAIT_ACK;
            WAIT_ACK: begin
                if (err) begin
                    st_d = ERROR;
                end else if (Bus2IP_Mst_CmdAck && Bus2IP_Mst_Cmplt) begin
                    st_d = PUSH;
                end else if (Bus2IP_Mst_CmdAck) begin
                    st_d = WAIT_CMPLT;
                end
            end
            WAIT_CMPLT: begin
                if (err) begin
                    st_d = ERROR;
                end else if (Bus2IP_Mst_Cmplt) begin
                    st_d = PUSH;
                end
            end
            // The bus transfer is finished here, so only reset may abandon the pixel.
            PUSH: begin
                if (reset) begin
                    st_d = ERROR;
                end else if (!rsp_full) begin
                    st_d   = IDLE;
                    push_d = 1'b1;
                end
            end
            ERROR:      st_d = err ? ERROR : IDLE;
            default:    st_d = ERROR;
        endcase
    end

    always_ff @(posedge PLB_clk) begin
        if (reset) begin
            st_q             <= ERROR;
            req_rd_en        <= 1'b0;
            rsp_wr_en        <= 1'b0;
            IP2Bus_Mst_Reset <= 1'b1;
            line_q           <= '0;
            col_q            <= '0;
            color_q          <= '0;
        end else begin
            st_q             <= st_d;
            req_rd_en        <= pop_d;
            rsp_wr_en        <= push_d;
            IP2Bus_Mst_Reset <= (st_q == ERROR);
            if (st_q == PRESENT) begin
                line_q <= req_line;
                col_q  <= req_col;
            end
            if (rd_phase && !Bus2IP_MstRd_src_rdy_n) begin
                color_q <= Bus2IP_MstRd_d;
            end
        end
    end

    // The popped word is only on req_data during PRESENT, so the address bypasses the latch then.
    assign addr_line = (st_q == PRESENT) ? req_line : line_q;
    assign addr_col  = (st_q == PRESENT) ? req_col  : col_q;

    fb_addr_gen u_addr (
        .line (addr_line),
        .col  (addr_col),
        .addr (IP2Bus_Mst_Addr)
    );

    assign state                  = st_q;
    assign rsp_data               = pack_rsp(line_q, col_q, color_q);
    assign IP2Bus_MstRd_Req       = (st_q == PRESENT) || (st_q == WAIT_ACK);
    assign IP2Bus_MstRd_dst_rdy_n = ~rd_phase;
    assign IP2Bus_MstWr_Req       = 1'b0;
    assign IP2Bus_Mst_BE          = '1;
    assign IP2Bus_Mst_Lock        = 1'b0;
    assign IP2Bus_MstWr_d         = '0;

endmodule

// File: tb/tb_fbreader.sv
// Directed-plus-random bench for fbreader: request FIFO model, scripted PLB slave, pixel scoreboard.
module tb_fbreader;

    logic        PLB_clk = 1'b0;
    logic        reset;
    logic [3:0]  state;
    logic [31:0] req_data;
    logic        req_empty;
    logic        req_rd_en;
    logic [63:0] rsp_data;
    logic        rsp_full;
    logic        rsp_wr_en;
    logic        IP2Bus_MstRd_Req;
    logic        IP2Bus_MstWr_Req;
    logic [31:0] IP2Bus_Mst_Addr;
    logic [3:0]  IP2Bus_Mst_BE;
    logic        IP2Bus_Mst_Lock;
    logic        IP2Bus_Mst_Reset;
    logic        Bus2IP_Mst_CmdAck;
    logic        Bus2IP_Mst_Cmplt;
    logic        Bus2IP_Mst_Error;
    logic        Bus2IP_Mst_Rearbitrate;
    logic        Bus2IP_Mst_Cmd_Timeout;
    logic [31:0] Bus2IP_MstRd_d;
    logic        Bus2IP_MstRd_src_rdy_n;
    logic        IP2Bus_MstRd_dst_rdy_n;
    logic [31:0] IP2Bus_MstWr_d;

    fbreader dut (
        .PLB_clk                (PLB_clk),
        .reset                  (reset),
        .state                  (state),
        .req_data               (req_data),
        .req_empty              (req_empty),
        .req_rd_en              (req_rd_en),
        .rsp_data               (rsp_data),
        .rsp_full               (rsp_full),
        .rsp_wr_en              (rsp_wr_en),
        .IP2Bus_MstRd_Req       (IP2Bus_MstRd_Req),
        .IP2Bus_MstWr_Req       (IP2Bus_MstWr_Req),
        .IP2Bus_Mst_Addr        (IP2Bus_Mst_Addr),
        .IP2Bus_Mst_BE          (IP2Bus_Mst_BE),
        .IP2Bus_Mst_Lock        (IP2Bus_Mst_Lock),
        .IP2Bus_Mst_Reset       (IP2Bus_Mst_Reset),
        .Bus2IP_Mst_CmdAck      (Bus2IP_Mst_CmdAck),
        .Bus2IP_Mst_Cmplt       (Bus2IP_Mst_Cmplt),
        .Bus2IP_Mst_Error       (Bus2IP_Mst_Error),
        .Bus2IP_Mst_Rearbitrate (Bus2IP_Mst_Rearbitrate),
        .Bus2IP_Mst_Cmd_Timeout (Bus2IP_Mst_Cmd_Timeout),
        .Bus2IP_MstRd_d         (Bus2IP_MstRd_d),
        .Bus2IP_MstRd_src_rdy_n (Bus2IP_MstRd_src_rdy_n),
        .IP2Bus_MstRd_dst_rdy_n (IP2Bus_MstRd_dst_rdy_n),
        .IP2Bus_MstWr_d         (IP2Bus_MstWr_d)
    );

    always #5 PLB_clk = ~PLB_clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rd_cnt = 0;
    int          total_reqs = 0;
    logic [31:0] req_q[$];
    logic [63:0] got_q[$];
    int          got_cyc[$];
    logic [63:0] exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe at the falling edge, update the FIFO model and the push log.
    task automatic tick();
        @(negedge PLB_clk);
        cyc++;
        if (req_rd_en === 1'b1) begin
            rd_cnt++;
            if (req_q.size() > 0) req_data = req_q.pop_front();
        end
        req_empty = (req_q.size() == 0);
        if (rsp_wr_en === 1'b1) begin
            got_q.push_back(rsp_data);
            got_cyc.push_back(cyc);
        end
    endtask

    task automatic add_req(input logic [31:0] w);
        req_q.push_back(w);
        req_empty = 1'b0;
        total_reqs++;
    endtask

    function automatic logic [31:0] rand_req();
        logic [31:0] w;
        w = (32'($urandom_range(0, 511)) << 16) | 32'($urandom_range(0, 1023));
        return w | ($urandom() & 32'hFE00_FC00);
    endfunction

    task automatic wait_req();
        int n;
        n = 0;
        while (IP2Bus_MstRd_Req !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        chk("rd_req_rise", 64'(IP2Bus_MstRd_Req), 64'd1);
        chk("state_present", 64'(state), 64'd1);
    endtask

    task automatic beat(input logic [31:0] dat, input int full_cyc);
        Bus2IP_Mst_Cmplt       = 1'b1;
        Bus2IP_MstRd_src_rdy_n = 1'b0;
        Bus2IP_MstRd_d         = dat;
        rsp_full               = (full_cyc > 0);
    endtask

    // Act as the PLB slave for one pixel read and record the pixel the engine must deliver.
    task automatic serve(input logic [31:0] req, input int ack_dly, input int cmp_dly,
                         input int full_cyc, input logic [31:0] dat);
        logic [31:0] line, col, ea;
        int          rd_base;
        line = (req >> 16) & 32'h1FF;
        col  = req & 32'h3FF;
        ea   = 32'h9000_0000 | (line << 12) | (col << 2);
        exp_q.push_back((64'(line) << 48) | (64'(col) << 32) | 64'(dat));
        wait_req();
        chk("mst_addr", 64'(IP2Bus_Mst_Addr), 64'(ea));
        repeat (ack_dly + 1) tick();
        chk("rd_req_held", 64'(IP2Bus_MstRd_Req), 64'd1);
        chk("state_wait_ack", 64'(state), 64'd2);
        chk("dst_rdy_n_low", 64'(IP2Bus_MstRd_dst_rdy_n), 64'd0);
        Bus2IP_Mst_CmdAck = 1'b1;
        if (cmp_dly == 0) beat(dat, full_cyc);
        tick();
        Bus2IP_Mst_CmdAck = 1'b0;
        if (cmp_dly > 0) begin
            chk("rd_req_after_ack", 64'(IP2Bus_MstRd_Req), 64'd0);
            chk("state_wait_cmplt", 64'(state), 64'd3);
            if (cmp_dly >= 2) begin
                Bus2IP_MstRd_d         = dat;
                Bus2IP_MstRd_src_rdy_n = 1'b0;
                tick();
                Bus2IP_MstRd_d         = ~dat;
                Bus2IP_MstRd_src_rdy_n = 1'b1;
                repeat (cmp_dly - 2) tick();
                Bus2IP_Mst_Cmplt = 1'b1;
                rsp_full         = (full_cyc > 0);
            end else begin
                beat(dat, full_cyc);
            end
            tick();
        end
        Bus2IP_Mst_Cmplt       = 1'b0;
        Bus2IP_MstRd_src_rdy_n = 1'b1;
        Bus2IP_MstRd_d         = $urandom();
        chk("state_push", 64'(state), 64'd6);
        if (full_cyc > 0) begin
            rd_base          = rd_cnt;
            Bus2IP_Mst_Error = 1'b1;
            for (int i = 1; i < full_cyc; i++) begin
                tick();
                chk("hold_no_push", 64'(rsp_wr_en), 64'd0);
                chk("hold_in_push", 64'(state), 64'd6);
            end
            Bus2IP_Mst_Error = 1'b0;
            rsp_full         = 1'b0;
            tick();
            chk("push_after_drop", 64'(rsp_wr_en), 64'd1);
            chk("hold_no_pop", 64'(rd_cnt), 64'(rd_base));
        end
    endtask

    task automatic check_push(input string tag, output int c);
        int n;
        n = 0;
        c = -1;
        while (got_q.size() == 0 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_seen"}, 64'(got_q.size() != 0), 64'd1);
        if (got_q.size() != 0 && exp_q.size() != 0) begin
            chk({tag, "_rsp_data"}, got_q.pop_front(), exp_q.pop_front());
            c = got_cyc.pop_front();
        end
    endtask

    // Abort a read with an error in WAIT_ACK or WAIT_CMPLT; the pixel must never be pushed.
    task automatic err_case(input bit tmo, input bit in_cmplt);
        add_req(rand_req());
        wait_req();
        tick();
        if (in_cmplt) begin
            Bus2IP_Mst_CmdAck = 1'b1;
            tick();
            Bus2IP_Mst_CmdAck = 1'b0;
            chk("err_pre_state", 64'(state), 64'd3);
        end
        if (tmo) Bus2IP_Mst_Cmd_Timeout = 1'b1;
        else     Bus2IP_Mst_Error = 1'b1;
        tick();
        Bus2IP_Mst_Cmd_Timeout = 1'b0;
        Bus2IP_Mst_Error       = 1'b0;
        chk("err_state", 64'(state), 64'd4);
        chk("err_req_low", 64'(IP2Bus_MstRd_Req), 64'd0);
        chk("mst_reset_not_yet", 64'(IP2Bus_Mst_Reset), 64'd0);
        tick();
        chk("err_exit_idle", 64'(state), 64'd0);
        chk("mst_reset_pulse", 64'(IP2Bus_Mst_Reset), 64'd1);
        tick();
        chk("mst_reset_clear", 64'(IP2Bus_Mst_Reset), 64'd0);
        chk("err_no_push", 64'(got_q.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] w;
        logic [31:0] burst[4];
        int          pc[4];
        int          c;
        int          rd0;

        reset                  = 1'b1;
        req_data               = '0;
        req_empty              = 1'b1;
        rsp_full               = 1'b0;
        Bus2IP_Mst_CmdAck      = 1'b0;
        Bus2IP_Mst_Cmplt       = 1'b0;
        Bus2IP_Mst_Error       = 1'b0;
        Bus2IP_Mst_Rearbitrate = 1'b0;
        Bus2IP_Mst_Cmd_Timeout = 1'b0;
        Bus2IP_MstRd_d         = '0;
        Bus2IP_MstRd_src_rdy_n = 1'b1;

        tick();
        chk("rst_state_error", 64'(state), 64'd4);
        chk("rst_rd_en", 64'(req_rd_en), 64'd0);
        chk("rst_wr_en", 64'(rsp_wr_en), 64'd0);
        chk("rst_rd_req", 64'(IP2Bus_MstRd_Req), 64'd0);
        chk("rst_mst_reset", 64'(IP2Bus_Mst_Reset), 64'd1);
        chk("be_all_ones", 64'(IP2Bus_Mst_BE), 64'hF);
        chk("wr_req_zero", 64'(IP2Bus_MstWr_Req), 64'd0);
        chk("lock_zero", 64'(IP2Bus_Mst_Lock), 64'd0);
        chk("wr_d_zero", 64'(IP2Bus_MstWr_d), 64'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("post_rst_idle", 64'(state), 64'd0);
        chk("post_rst_mst_reset", 64'(IP2Bus_Mst_Reset), 64'd1);
        chk("post_rst_rsp_data", rsp_data, 64'd0);
        tick();
        chk("mst_reset_drop", 64'(IP2Bus_Mst_Reset), 64'd0);
        chk("idle_dst_rdy_n", 64'(IP2Bus_MstRd_dst_rdy_n), 64'd1);

        w = 32'h0005_0011;
        add_req(w);
        serve(w, 1, 0, 0, 32'hAABB_CCDD);
        check_push("single", c);

        w = rand_req();
        add_req(w);
        serve(w, 0, 0, 0, 32'h1234_5678);
        check_push("same_cycle", c);

        w = rand_req();
        add_req(w);
        add_req(32'h01FF_03FF);
        serve(w, 0, 1, 10, 32'hCAFE_F00D);
        check_push("backpressure", c);
        serve(32'h01FF_03FF, 2, 3, 0, 32'h0BAD_C0DE);
        check_push("after_backpressure", c);

        err_case(1'b0, 1'b1);
        w = rand_req();
        add_req(w);
        serve(w, 0, 2, 0, $urandom());
        check_push("after_bus_error", c);

        err_case(1'b1, 1'b0);
        w = rand_req();
        add_req(w);
        serve(w, 1, 1, 0, $urandom());
        check_push("after_timeout", c);

        add_req(rand_req());
        wait_req();
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("rst_mid_req_drop", 64'(IP2Bus_MstRd_Req), 64'd0);
        chk("rst_mid_err1", 64'(state), 64'd4);
        tick();
        chk("rst_mid_err2", 64'(state), 64'd4);
        tick();
        chk("rst_mid_err3", 64'(state), 64'd4);
        chk("rst_mid_mst_reset", 64'(IP2Bus_Mst_Reset), 64'd1);
        reset = 1'b0;
        tick();
        chk("rst_mid_recover", 64'(state), 64'd0);
        repeat (4) tick();
        chk("rst_mid_no_push", 64'(got_q.size()), 64'd0);

        rd0 = rd_cnt;
        for (int i = 0; i < 4; i++) begin
            burst[i] = rand_req();
            add_req(burst[i]);
        end
        for (int i = 0; i < 4; i++) begin
            serve(burst[i], 0, 0, 0, $urandom());
            check_push("burst", pc[i]);
        end
        for (int i = 1; i < 4; i++) begin
            chk("burst_spacing_ge5", 64'((pc[i] - pc[i-1]) >= 5), 64'd1);
        end
        chk("burst_pops", 64'(rd_cnt - rd0), 64'd4);

        for (int i = 0; i < 12; i++) begin
            w = rand_req();
            add_req(w);
            serve(w, $urandom_range(0, 3), $urandom_range(0, 3),
                  ($urandom_range(0, 2) == 0) ? $urandom_range(1, 4) : 0, $urandom());
            check_push("random", c);
        end

        repeat (6) tick();
        chk("total_pops", 64'(rd_cnt), 64'(total_reqs));
        chk("no_extra_push", 64'(got_q.size()), 64'd0);
        chk("no_missing_push", 64'(exp_q.size()), 64'd0);
        chk("end_idle", 64'(state), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
